// File: rtl/octal_step_counter.sv
// -----------------------------------------------------------------------------
// octal_step_counter
//
// Turns three raw, bouncing, active-low pushbuttons into a clean 3-bit value
// that feeds the seven-segment decoder directly.  Each button passes through a
// two-flop synchroniser and a hold-time debouncer.  The falling edge of the
// debounced level (a press) becomes a single-cycle event.  Events then step,
// load or leave the modulo-8 count.
//
// Ports
//   CLOCK_50  in   system clock, all state on its rising edge
//   RESET     in   asynchronous, active-high reset
//   KEY_UP    in   raw pushbutton, active-low, asynchronous to CLOCK_50
//   KEY_DOWN  in   raw pushbutton, active-low, asynchronous to CLOCK_50
//   KEY_LOAD  in   raw pushbutton, active-low, asynchronous to CLOCK_50
//   SW[2:0]   in   value loaded on a KEY_LOAD press (quasi-static)
//   COUNT[2:0] out current value, registered
//   STEP      out  one-cycle pulse when COUNT is updated by an accepted event
//   WRAP      out  one-cycle pulse on 7->0 (up) or 0->7 (down)
// -----------------------------------------------------------------------------
module octal_step_counter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    input  logic       KEY_LOAD,
    input  logic [2:0] SW,
    output logic [2:0] COUNT,
    output logic       STEP,
    output logic       WRAP
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button index: 0 = up, 1 = down, 2 = load.
    logic [2:0]       raw;
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       level;
    logic [2:0]       level_d;
    logic [CNT_W-1:0] db_cnt [3];
    logic [2:0]       press;

    logic [2:0] count_next;
    logic       step_next;
    logic       wrap_next;

    assign raw = {KEY_LOAD, KEY_DOWN, KEY_UP};

    // Synchroniser plus a delayed copy of the debounced level for edge
    // detection.  Everything resets to "released" (1).
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync_a  <= 3'b111;
            sync_b  <= 3'b111;
            level_d <= 3'b111;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_d <= level;
        end
    end

    // Debouncer: the synchronised sample must differ from the accepted level
    // for DEBOUNCE_CYCLES consecutive edges before it is taken.  Any sample
    // that agrees with the current level restarts the count, so a single
    // bounce discards all progress.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            level <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_b[i] != level[i]) begin
                    if (db_cnt[i] == LAST) begin
                        level[i]  <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Press = debounced level fell on the previous edge; releases are ignored.
    assign press = level_d & ~level;

    // Event resolution: load wins over everything; simultaneous up and down
    // cancel each other and produce no step.
    always_comb begin
        count_next = COUNT;
        step_next  = 1'b0;
        wrap_next  = 1'b0;
        if (press[2]) begin
            count_next = SW;
            step_next  = 1'b1;
        end else if (press[0] && !press[1]) begin
            count_next = COUNT + 3'd1;
            step_next  = 1'b1;
            wrap_next  = (COUNT == 3'd7);
        end else if (press[1] && !press[0]) begin
            count_next = COUNT - 3'd1;
            step_next  = 1'b1;
            wrap_next  = (COUNT == 3'd0);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            COUNT <= 3'd0;
            STEP  <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            COUNT <= count_next;
            STEP  <= step_next;
            WRAP  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_octal_step_counter.sv
// -----------------------------------------------------------------------------
// tb_octal_step_counter
//
// Directed bench for octal_step_counter with a short debounce time.  Each
// press pushes the expected COUNT/WRAP and the exact cycle of the STEP pulse
// onto a scoreboard; a monitor on the falling clock edge pops and compares.
// On cycles without a queued entry STEP and WRAP must be low.
// -----------------------------------------------------------------------------
module tb_octal_step_counter;

    localparam int D = 4;

    localparam logic [2:0] M_UP   = 3'b001;
    localparam logic [2:0] M_DOWN = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b100;

    logic       clk;
    logic       rst;
    logic       key_up;
    logic       key_down;
    logic       key_load;
    logic [2:0] sw;
    logic [2:0] count;
    logic       step;
    logic       wrap;

    typedef struct {
        int         cyc;
        logic [2:0] cnt;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    octal_step_counter #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .KEY_UP  (key_up),
        .KEY_DOWN(key_down),
        .KEY_LOAD(key_load),
        .SW      (sw),
        .COUNT   (count),
        .STEP    (step),
        .WRAP    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("step_pulse", step, 1);
            chk("step_count", count, q[0].cnt);
            chk("step_wrap", wrap, q[0].wrap);
            void'(q.pop_front());
        end else begin
            chk("step_idle", step, 0);
            chk("wrap_idle", wrap, 0);
        end
    end

    task automatic expect_at(input int t, input logic [2:0] c, input logic w);
        exp_t e;
        e.cyc  = t;
        e.cnt  = c;
        e.wrap = w;
        q.push_back(e);
    endtask

    // Press the buttons in mask m with identical timing, hold for `hold`
    // edges, release and wait for the release to settle.  The first edge
    // after the drive is edge 1; the update lands on edge 3+D.
    task automatic press(input logic [2:0] m, input int hold, input logic ev,
                         input logic [2:0] c, input logic w);
        int t0;
        @(posedge clk);
        #1;
        t0       = cyc;
        key_up   = ~m[0];
        key_down = ~m[1];
        key_load = ~m[2];
        if (ev) expect_at(t0 + 3 + D, c, w);
        repeat (hold) @(posedge clk);
        #1;
        key_up   = 1'b1;
        key_down = 1'b1;
        key_load = 1'b1;
        repeat (D + 4) @(posedge clk);
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        rst      = 1'b1;
        key_up   = 1'b1;
        key_down = 1'b1;
        key_load = 1'b1;
        sw       = 3'd0;

        // Reset and idle.
        edges(2);
        chk("reset_count", count, 0);
        chk("reset_step", step, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            edges(1);
            chk("idle_count", count, 0);
        end

        // Long hold: exactly one increment at edge 3+D.
        press(M_UP, 50, 1'b1, 3'd1, 1'b0);
        chk("hold_count", count, 1);

        // Eight re-presses: 2..7, 0 (wrap), 1.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] nv;
            nv = 3'((i + 2) % 8);
            press(M_UP, 10, 1'b1, nv, (nv == 3'd0));
        end
        chk("repress_count", count, 1);

        // Bounce: low 3 edges, high 1 edge, five times, then steady low.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            key_up = 1'b0;
            edges(3);
            key_up = 1'b1;
            edges(1);
        end
        key_up = 1'b0;
        t0     = cyc;
        expect_at(t0 + 3 + D, 3'd2, 1'b0);
        edges(20);
        key_up = 1'b1;
        edges(D + 4);
        chk("bounce_count", count, 2);

        // Down to 0, then down wraps to 7.
        press(M_DOWN, 10, 1'b1, 3'd1, 1'b0);
        press(M_DOWN, 10, 1'b1, 3'd0, 1'b0);
        press(M_DOWN, 10, 1'b1, 3'd7, 1'b1);
        chk("down_wrap_count", count, 7);

        // Load overrides up; loading from 7 to 5 reports no wrap.
        sw = 3'b101;
        press(M_LOAD | M_UP, 10, 1'b1, 3'd5, 1'b0);
        chk("load_count", count, 5);

        // Loading the value already held still pulses STEP.
        press(M_LOAD, 10, 1'b1, 3'd5, 1'b0);

        // Up and down together cancel: no step.
        press(M_UP | M_DOWN, 10, 1'b0, 3'd0, 1'b0);
        chk("updown_count", count, 5);

        // Reset asserted mid-cycle clears COUNT without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_count", count, 0);

        // Button held low across reset release: one event at edge 3+D.
        key_up = 1'b0;
        edges(3);
        rst = 1'b0;
        t0  = cyc;
        expect_at(t0 + 3 + D, 3'd1, 1'b0);
        edges(30);
        key_up = 1'b1;
        edges(D + 4);
        chk("held_reset_count", count, 1);

        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/octal_step_counter.md
Name: octal_step_counter

Overview:
- Upstream feeder for the 3-bit seven-segment decoder stage; its COUNT output drives that decoder's 3-bit value input directly.
- Turns three raw board pushbuttons into a clean 3-bit value: up, down and load-from-switches.
- Each button is synchronised, debounced and edge-detected; COUNT wraps modulo 8.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clocks a synchronised button level must hold before it is accepted (10 ms at 50 MHz); legal range 2..2^20.
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  input  1  system clock; all state on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- KEY_UP  input  1  raw pushbuttons, active-low (0 = pressed), asynchronous to CLOCK_50; same for KEY_DOWN and KEY_LOAD.
- KEY_DOWN  input  1  raw pushbutton, active-low.
- KEY_LOAD  input  1  raw pushbutton, active-low.
- SW  input  3  value loaded on a KEY_LOAD press; sampled directly, treated as quasi-static.
- COUNT  output  3  current value, registered.
- STEP  output  1  one-cycle pulse in the cycle COUNT is updated by an accepted event.
- WRAP  output  1  one-cycle pulse on 7->0 by up or 0->7 by down.

Behaviour:
- Reset, asynchronous while RESET=1:
  - COUNT=0, STEP=0, WRAP=0.
  - All synchroniser flops = 1 and all debounced levels = 1 (released).
  - All debounce counters = 0.
  - Releasing reset mid-debounce discards all progress.
- Per button, identical and independent:
  - Two-flop synchroniser, then debounced level L, then counter C.
  - Each edge where synchronised sample S != L: C increments.
  - When S != L and C == DEBOUNCE_CYCLES-1: L <= S and C <= 0.
  - Each edge where S == L: C <= 0. Any glitch restarts the count.
- Press event: a one-cycle internal strobe on the edge where L goes 1->0. Releases (0->1) generate no event.
- Latency: raw input held low from before edge 1:
  - S = 0 at edge 2.
  - L = 0 at edge 2+DEBOUNCE_CYCLES.
  - COUNT and STEP update at edge 3+DEBOUNCE_CYCLES.
- Event resolution, same edge, registered:
  - Load event: COUNT <= SW, STEP=1, WRAP=0. Load overrides up/down.
  - Only up event: COUNT <= COUNT+1 mod 8, STEP=1, WRAP=1 iff old COUNT=7.
  - Only down event: COUNT <= COUNT-1 mod 8, STEP=1, WRAP=1 iff old COUNT=0.
  - Up and down in the same cycle with no load: no change, STEP=0, WRAP=0.
  - No event: COUNT holds, STEP=0, WRAP=0.
- Loading SW equal to current COUNT still pulses STEP.
- A held button produces exactly one event. No auto-repeat.
- A button held low across reset deassertion produces one press event at edge 3+DEBOUNCE_CYCLES after release of RESET.
- Arithmetic is 3-bit unsigned with natural wrap. There is no saturation.
- Outputs are glitch-free registered signals. COUNT connects straight to the decoder.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset then idle 20 cycles -> COUNT=0, STEP=0, WRAP=0 throughout. Assert RESET mid-run with COUNT=5 -> COUNT=0 immediately, without waiting for a clock edge.
- KEY_UP low from before edge 1 and held 50 cycles -> COUNT 0->1 exactly at edge 7. STEP high for that single cycle. No further increments while held. Release and re-press 8 times -> sequence 2..7,0,1 with WRAP only on the 7->0 step.
- KEY_UP bounce (low 3 cycles, high 1, low 3, high 1, repeated 5 times) then steady low -> no event during the bounce. Exactly one increment, 7 cycles after the last low transition is sampled at edge 1 of the steady low.
- From COUNT=0, press KEY_DOWN -> COUNT=7, WRAP=1, STEP=1 for one cycle.
- SW=3'b101, press KEY_LOAD and KEY_UP with identical timing -> COUNT=5, WRAP=0. Then press KEY_UP and KEY_DOWN with identical timing -> COUNT stays 5, STEP=0.
- Hold KEY_UP low through RESET deassertion -> exactly one increment (COUNT=1) at edge 7 after reset release. With DEBOUNCE_CYCLES=2 (minimum) -> the same scenarios pass with edge 5.
